// File: rtl/mem_bus_pkg.sv
// Shared region codes, blank-digit constant and address decode for the memory-mapped bus stage.
package mem_bus_pkg;

    typedef enum logic [2:0] {
        REG_RAM    = 3'd0,
        REG_LED    = 3'd1,
        REG_HEX    = 3'd2,
        REG_SW     = 3'd3,
        REG_STATUS = 3'd4,
        REG_NONE   = 3'd5
    } region_e;

    localparam logic [6:0] HEX_BLANK = 7'h7F;

    function automatic region_e decode_region(input logic [15:0] addr);
        case (addr[15:12])
            4'h0:    return REG_RAM;
            4'h1:    return REG_LED;
            4'h2:    return REG_HEX;
            4'h3:    return REG_SW;
            4'h4:    return REG_STATUS;
            default: return REG_NONE;
        endcase
    endfunction

endpackage

// File: rtl/mem_bus_ctrl_sw_sync.sv
// Two-flop synchroniser bringing the asynchronous switch inputs into the clk domain.
module sw_sync #(
    parameter int W = 10
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] stage1_q;
    logic [W-1:0] stage2_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stage1_q <= '0;
            stage2_q <= '0;
        end else begin
            stage1_q <= d;
            stage2_q <= stage1_q;
        end
    end

    assign q = stage2_q;

endmodule

// File: rtl/mem_bus_ctrl.sv
// Bus stage behind the processor: decodes each access to RAM / LED / HEX / SW / STATUS and
// returns read data on din with one-cycle latency.
module mem_bus_ctrl
    import mem_bus_pkg::*;
#(
    parameter int RAM_AW = 8,
    parameter int LED_W  = 10,
    parameter int SW_W   = 10,
    parameter int HEX_N  = 6
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [15:0]          addr,
    input  logic [15:0]          dout,
    input  logic                 w,
    output logic [15:0]          din,
    output logic [RAM_AW-1:0]    ram_addr,
    output logic [15:0]          ram_wdata,
    output logic                 ram_we,
    input  logic [15:0]          ram_rdata,
    input  logic [SW_W-1:0]      sw,
    output logic [LED_W-1:0]     led,
    output logic [7*HEX_N-1:0]   hex_flat,
    output logic                 bus_err
);

    region_e                 region_d, region_q;
    logic [LED_W-1:0]        led_d, led_q;
    logic [HEX_N-1:0][6:0]   hex_d, hex_q;
    logic                    bus_err_d, bus_err_q;
    logic [15:0]             cap_d, cap_q;
    logic [SW_W-1:0]         sw_s;
    logic [2:0]              hex_idx;
    logic                    hex_ok;
    logic [6:0]              hex_rd;
    logic                    unused_addr;

    sw_sync #(.W(SW_W)) u_sw_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (sw),
        .q       (sw_s)
    );

    assign hex_idx     = addr[2:0];
    assign region_d    = decode_region(addr);
    assign unused_addr = ^addr;

    assign ram_addr  = addr[RAM_AW-1:0];
    assign ram_wdata = dout;
    assign ram_we    = reset_n && w && (region_d == REG_RAM);

    // NOTE: every variable assigned in always_comb gets a default first, otherwise a latch is inferred.
    always_comb begin
        hex_ok = 1'b0;
        hex_rd = '0;
        for (int i = 0; i < HEX_N; i++) begin
            if (hex_idx == 3'(i)) begin
                hex_ok = 1'b1;
                hex_rd = hex_q[i];
            end
        end
    end

    // Captured read value uses pre-write state, giving read-before-write on the same register.
    always_comb begin
        led_d     = led_q;
        hex_d     = hex_q;
        bus_err_d = bus_err_q;
        cap_d     = '0;

        case (region_d)
            REG_LED:    cap_d[LED_W-1:0] = led_q;
            REG_HEX:    cap_d[6:0]       = hex_rd;
            REG_SW:     cap_d[SW_W-1:0]  = sw_s;
            REG_STATUS: cap_d[0]         = bus_err_q;
            default:    cap_d            = '0;
        endcase

        if (w) begin
            case (region_d)
                REG_LED:    led_d = dout[LED_W-1:0];
                REG_HEX: begin
                    if (hex_ok) begin
                        for (int i = 0; i < HEX_N; i++) begin
                            if (hex_idx == 3'(i)) hex_d[i] = dout[6:0];
                        end
                    end else begin
                        bus_err_d = 1'b1;
                    end
                end
                REG_STATUS: bus_err_d = 1'b0;
                REG_SW,
                REG_NONE:   bus_err_d = 1'b1;
                default:    ;
            endcase
        end
    end

    // NOTE: the small digit/LED registers are reset; the external RAM array is deliberately not.
    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            led_q     <= '0;
            hex_q     <= {HEX_N{HEX_BLANK}};
            bus_err_q <= 1'b0;
            region_q  <= REG_NONE;
            cap_q     <= '0;
        end else begin
            led_q     <= led_d;
            hex_q     <= hex_d;
            bus_err_q <= bus_err_d;
            region_q  <= region_d;
            cap_q     <= cap_d;
        end
    end

    assign din      = (region_q == REG_RAM) ? ram_rdata : cap_q;
    assign led      = led_q;
    assign hex_flat = hex_q;
    assign bus_err  = bus_err_q;

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Self-checking bench for mem_bus_ctrl: directed vector table, hand sequences, and a randomized
// run against a register-level reference model with an old-data RAM attached.
module tb_mem_bus_ctrl;

    localparam int RAM_AW = 8;
    localparam int LED_W  = 10;
    localparam int SW_W   = 10;
    localparam int HEX_N  = 6;

    logic                clk = 1'b0;
    logic                reset_n;
    logic [15:0]         addr, dout, din, ram_wdata, ram_rdata;
    logic                w, ram_we, bus_err;
    logic [RAM_AW-1:0]   ram_addr;
    logic [SW_W-1:0]     sw;
    logic [LED_W-1:0]    led;
    logic [7*HEX_N-1:0]  hex_flat;

    int n_cmp  = 0;
    int n_fail = 0;

    mem_bus_ctrl #(.RAM_AW(RAM_AW), .LED_W(LED_W), .SW_W(SW_W), .HEX_N(HEX_N)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .addr      (addr),
        .dout      (dout),
        .w         (w),
        .din       (din),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_we    (ram_we),
        .ram_rdata (ram_rdata),
        .sw        (sw),
        .led       (led),
        .hex_flat  (hex_flat),
        .bus_err   (bus_err)
    );

    always #5 clk = ~clk;

    // External synchronous RAM, old-data on same-address read/write.
    logic [15:0] ram_mem [2**RAM_AW];
    always @(posedge clk) begin
        if (ram_we) ram_mem[ram_addr] <= ram_wdata;
        ram_rdata <= ram_mem[ram_addr];
    end

    // Reference model state.
    logic [15:0]     ref_mem [2**RAM_AW];
    logic [LED_W-1:0] m_led;
    logic [6:0]      m_hex [HEX_N];
    logic            m_err;
    logic [SW_W-1:0] sw_hist [$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_led = '0;
        m_err = 1'b0;
        for (int i = 0; i < HEX_N; i++) m_hex[i] = 7'h7F;
        sw_hist = {};
        sw_hist.push_back('0);
        sw_hist.push_back('0);
    endtask

    function automatic logic [7*HEX_N-1:0] model_hex_flat();
        logic [7*HEX_N-1:0] f;
        for (int i = 0; i < HEX_N; i++) f[7*i +: 7] = m_hex[i];
        return f;
    endfunction

    // One clock edge of the architectural behaviour: read value from pre-edge state, then the write.
    task automatic model_step(output logic [15:0] exp_din, output logic exp_we);
        int r;
        int idx;
        r   = int'(addr[15:12]);
        idx = int'(addr[2:0]);
        exp_we  = w && (r == 0);
        exp_din = 16'h0000;
        case (r)
            0: exp_din = ref_mem[addr[RAM_AW-1:0]];
            1: exp_din = 16'(m_led);
            2: exp_din = (idx < HEX_N) ? 16'(m_hex[idx]) : 16'h0000;
            3: exp_din = 16'(sw_hist[sw_hist.size()-2]);
            4: exp_din = {15'b0, m_err};
            default: exp_din = 16'h0000;
        endcase
        sw_hist.push_back(sw);
        if (sw_hist.size() > 4) void'(sw_hist.pop_front());
        if (w) begin
            case (r)
                0: ref_mem[addr[RAM_AW-1:0]] = dout;
                1: m_led = dout[LED_W-1:0];
                2: if (idx < HEX_N) m_hex[idx] = dout[6:0]; else m_err = 1'b1;
                4: m_err = 1'b0;
                default: m_err = 1'b1;
            endcase
        end
    endtask

    typedef struct {
        logic [15:0]      addr;
        logic [15:0]      dout;
        logic             w;
        logic [15:0]      exp_din;
        logic [LED_W-1:0] exp_led;
        logic             exp_err;
    } vec_t;

    vec_t vecs [12];

    initial begin
        logic [15:0]        e_din;
        logic               e_we;
        logic [7*HEX_N-1:0] e_hex;

        vecs[0]  = '{16'h1000, 16'h03A5, 1'b1, 16'h0000, 10'h3A5, 1'b0};
        vecs[1]  = '{16'h1000, 16'h0000, 1'b0, 16'h03A5, 10'h3A5, 1'b0};
        vecs[2]  = '{16'h2003, 16'h0040, 1'b1, 16'h007F, 10'h3A5, 1'b0};
        vecs[3]  = '{16'h2003, 16'h0000, 1'b0, 16'h0040, 10'h3A5, 1'b0};
        vecs[4]  = '{16'h2006, 16'h0012, 1'b1, 16'h0000, 10'h3A5, 1'b1};
        vecs[5]  = '{16'h4000, 16'h0000, 1'b0, 16'h0001, 10'h3A5, 1'b1};
        vecs[6]  = '{16'h4000, 16'hFFFF, 1'b1, 16'h0001, 10'h3A5, 1'b0};
        vecs[7]  = '{16'h4000, 16'h0000, 1'b0, 16'h0000, 10'h3A5, 1'b0};
        vecs[8]  = '{16'h5000, 16'h1234, 1'b1, 16'h0000, 10'h3A5, 1'b1};
        vecs[9]  = '{16'hF123, 16'h0000, 1'b0, 16'h0000, 10'h3A5, 1'b1};
        vecs[10] = '{16'h4000, 16'h0000, 1'b1, 16'h0001, 10'h3A5, 1'b0};
        vecs[11] = '{16'h3000, 16'h0055, 1'b1, 16'h0000, 10'h3A5, 1'b1};

        for (int i = 0; i < 2**RAM_AW; i++) begin
            ram_mem[i] = 16'h0000;
            ref_mem[i] = 16'h0000;
        end

        // Reset with a RAM write attempt pending: ram_we must stay low.
        reset_n = 1'b0;
        addr = 16'h0000;
        dout = 16'hAAAA;
        w    = 1'b1;
        sw   = '0;
        repeat (3) tick();
        check("reset_din", din, 16'h0000);
        check("reset_led", led, 10'h000);
        check("reset_hex", hex_flat, {HEX_N{7'h7F}});
        check("reset_err", bus_err, 1'b0);
        check("reset_we", ram_we, 1'b0);
        w       = 1'b0;
        reset_n = 1'b1;
        tick();

        for (int i = 0; i < 12; i++) begin
            addr = vecs[i].addr;
            dout = vecs[i].dout;
            w    = vecs[i].w;
            tick();
            check($sformatf("vec%0d_din", i), din, vecs[i].exp_din);
            check($sformatf("vec%0d_led", i), led, vecs[i].exp_led);
            check($sformatf("vec%0d_err", i), bus_err, vecs[i].exp_err);
        end
        e_hex = {HEX_N{7'h7F}};
        e_hex[27:21] = 7'h40;
        check("hex_digit3", hex_flat, e_hex);

        // RAM write then read: ram_we for one cycle, data one cycle after the read address.
        addr = 16'h0012;
        dout = 16'hBEEF;
        w    = 1'b1;
        #1;
        check("ram_we_hi", ram_we, 1'b1);
        check("ram_addr", ram_addr, 8'h12);
        check("ram_wdata", ram_wdata, 16'hBEEF);
        tick();
        ref_mem[8'h12] = 16'hBEEF;
        check("ram_old_data", din, 16'h0000);
        w = 1'b0;
        #1;
        check("ram_we_lo", ram_we, 1'b0);
        tick();
        check("ram_read", din, 16'hBEEF);

        // Switch synchroniser: new value appears from the third edge.
        addr = 16'h3000;
        sw   = 10'h2AA;
        tick();
        check("sw_edge1", din, 16'h0000);
        tick();
        check("sw_edge2", din, 16'h0000);
        tick();
        check("sw_edge3", din, 16'h02AA);

        // Reset asserted during an LED write: the write is lost.
        addr    = 16'h1000;
        dout    = 16'h0155;
        w       = 1'b1;
        reset_n = 1'b0;
        #1;
        check("midrst_led_async", led, 10'h000);
        tick();
        check("midrst_led", led, 10'h000);
        addr = 16'h0005;
        #1;
        check("midrst_we", ram_we, 1'b0);
        addr    = 16'h1000;
        w       = 1'b0;
        reset_n = 1'b1;
        tick();
        check("postrst_din", din, 16'h0000);
        check("postrst_err", bus_err, 1'b0);

        // Randomized run against the reference model from a fresh reset.
        reset_n = 1'b0;
        w       = 1'b0;
        tick();
        model_reset();
        reset_n = 1'b1;
        for (int n = 0; n < 400; n++) begin
            int r;
            r = $urandom_range(0, 7);
            if (r == 7) r = $urandom_range(5, 15);
            addr = {4'(r), 12'($urandom_range(0, 15))};
            dout = 16'($urandom);
            w    = ($urandom_range(0, 1) == 1);
            if ($urandom_range(0, 7) == 0) sw = SW_W'($urandom);
            #1;
            model_step(e_din, e_we);
            check("rnd_we", ram_we, e_we);
            tick();
            check("rnd_din", din, e_din);
            check("rnd_led", led, m_led);
            check("rnd_err", bus_err, m_err);
            check("rnd_hex", hex_flat, model_hex_flat());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_bus_ctrl.md
Name: mem_bus_ctrl

Overview:
- Memory-mapped bus stage directly downstream of the processor control path.
- Consumes the processor's address register, data-out register and registered write strobe.
- Decodes each access to one of these targets: synchronous RAM, LED register, HEX display registers, a switch input port, or a status register.
- Returns read data on the processor's DIN with fixed one-cycle latency, matching the T0→T2 fetch and the LD T3→T5 sequence.

Parameters:
- RAM_AW, 8, RAM word-address width; RAM depth is 2^RAM_AW 16-bit words.
- LED_W, 10, LED register width.
- SW_W, 10, switch input width.
- HEX_N, 6, number of 7-segment digit registers.

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- addr  in  16  address from the processor ADDR register.
- dout  in  16  write data from the processor DOUT register.
- w  in  1  active-high write strobe; sampled together with addr and dout.
- din  out  16  read data to the processor.
- ram_addr  out  RAM_AW  address to the external synchronous RAM; equals addr[RAM_AW-1:0].
- ram_wdata  out  16  equals dout.
- ram_we  out  1  asserted when w is high and the access hits the RAM region (combinational).
- ram_rdata  in  16  RAM read data, valid one cycle after ram_addr.
- sw  in  SW_W  asynchronous switch inputs.
- led  out  LED_W  LED register.
- hex_flat  out  7*HEX_N  digit registers concatenated, digit 0 in bits [6:0]; segments active-low.
- bus_err  out  1  sticky error flag (status bit 0).

Behaviour:
- Region decode uses addr[15:12]:
  - 0x0: RAM.
  - 0x1: LED.
  - 0x2: HEX; digit index is addr[2:0].
  - 0x3: SW (read-only).
  - 0x4: STATUS.
  - Any other value: unmapped.
- Write at a rising edge with w=1:
  - LED: led <= dout[LED_W-1:0].
  - HEX with index < HEX_N: that digit <= dout[6:0].
  - STATUS: bus_err <= 0, regardless of data.
  - RAM: ram_we is high during that cycle.
- Error writes:
  - A write to SW, to unmapped space, or to HEX with index ≥ HEX_N is ignored and sets bus_err.
- Reads, every cycle, independent of w:
  - At edge k the block registers region_q, along with cap_q, the non-RAM read value.
  - din is valid from edge k until edge k+1, and holds while addr is stable.
  - If region_q is RAM, din = ram_rdata.
  - Otherwise din = cap_q:
    - LED: zero-extended led.
    - HEX: zero-extended digit, or 0 for an invalid index.
    - SW: zero-extended synchronised sw.
    - STATUS: {15'b0, bus_err}.
    - Unmapped: 0.
- Reads never set or clear bus_err. A read of unmapped space returns 0 with no error.
- Same-cycle write and read of the same register: the captured value is the pre-write value (read-before-write). RAM same-address behaviour is defined by the RAM's old-data mode.
- Switch synchronisation: two flops. A change on sw is visible in cap_q no earlier than the third edge after it.
- Reset (asynchronous, active-low):
  - led = 0.
  - Every HEX digit = 7'h7F (blank).
  - bus_err = 0.
  - Synchroniser flops = 0.
  - region_q = unmapped code, so din = 0.
  - cap_q = 0.
- Reset asserted mid-access: a pending write is lost, and the next read after reset deasserts obeys normal latency.
- ram_we is never asserted while reset_n is low.

Decomposition:
- Package mem_bus_pkg holds:
  - region codes REG_RAM, REG_LED, REG_HEX, REG_SW, REG_STATUS, REG_NONE;
  - HEX_BLANK = 7'h7F;
  - the region decode function.
- One sub-module: sw_sync, a parameterised 2-flop synchroniser with async active-low reset.

Test Plan:
- Reset: hold reset_n low for 3 cycles → din=0, led=0, hex_flat all 1s, bus_err=0, ram_we=0.
- LED write/read: w=1, addr=0x1000, dout=0x03A5 → led=0x3A5 next edge; then addr=0x1000, w=0 → din=0x03A5 one cycle later.
- HEX: write 0x0040 to 0x2003 → digit 3 = 7'h40, others stay 7'h7F; write to 0x2006 → ignored, bus_err=1.
- Error clear: w=1, addr=0x5000 → bus_err=1; read 0x4000 → din=0x0001; write 0x4000 → bus_err=0; re-read → din=0.
- RAM: w=1, addr=0x0012, dout=0xBEEF → ram_we=1 that cycle only, with ram_addr=0x12; read 0x0012 with model RAM → din=0xBEEF exactly one cycle after addr.
- SW sync and reset mid-op: sw=0x2AA → a read at 0x3000 returns 0x02AA only from the 3rd edge onward; then assert reset_n low during a write to LED → led stays 0.
